// File: rtl/inst_queue_if.sv
// Fetch-to-decode bundle entry type and the inst_queue port bundle.
// Fetch/decode drive through the master modport; the queue uses slave.
package inst_queue_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] predict_pc_addr;
    logic            predict_brunch_taken;
    logic            is_valid;
  } decode_require_t;
endpackage

interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 4
);
  localparam int unsigned TAKE_W = $clog2(OUT_W + 1);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic                              in_valid;
  decode_require_t [IN_W-1:0]        in_bundle;
  logic                              in_ready;
  decode_require_t [OUT_W-1:0]       out_bundle;
  logic            [OUT_W-1:0]       out_valid;
  logic            [TAKE_W-1:0]      dec_take;
  logic            [CNT_W-1:0]       count;

  modport master (
    output in_valid, in_bundle, dec_take,
    input  in_ready, out_bundle, out_valid, count
  );

  modport slave (
    input  in_valid, in_bundle, dec_take,
    output in_ready, out_bundle, out_valid, count
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode: compacts valid slots of
// each incoming bundle, presents the oldest OUT_W entries and retires what decode takes.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  inst_queue_if.slave  q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  decode_require_t   mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  push_cnt;
  logic [CNT_W-1:0]  take_cnt;
  logic [PTR_W-1:0]  wr_idx [IN_W];
  logic              ready;
  logic              push_en;

  // Space check uses only the registered count, so a same-cycle pop never raises it.
  assign ready   = (count <= CNT_W'(DEPTH - IN_W));
  assign push_en = q.in_valid && ready && !flush;

  // Each valid slot lands at tail plus the number of valid slots below it.
  always_comb begin : compact
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(IN_W); i++) begin
      wr_idx[i] = tail + PTR_W'(acc);
      if (q.in_bundle[i].is_valid) acc = acc + CNT_W'(1);
    end
    push_cnt = acc;
  end

  // Retire count clamped to both the presentation width and the occupancy.
  always_comb begin : take_clamp
    logic [CNT_W-1:0] want;
    want = CNT_W'(q.dec_take);
    if (want > CNT_W'(OUT_W)) want = CNT_W'(OUT_W);
    take_cnt = (want > count) ? count : want;
  end

  always_ff @(posedge clk or negedge rst_n) begin : ptr_regs
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(take_cnt);
      if (push_en) tail <= tail + PTR_W'(push_cnt);
      count <= count + (push_en ? push_cnt : CNT_W'(0)) - take_cnt;
    end
  end

  always_ff @(posedge clk) begin : storage
    if (push_en) begin
      for (int i = 0; i < int'(IN_W); i++) begin
        if (q.in_bundle[i].is_valid) mem[wr_idx[i]] <= q.in_bundle[i];
      end
    end
  end

  // Slot j shows entry head+j; slots beyond the occupancy are forced to zero.
  always_comb begin : present
    logic vld;
    for (int j = 0; j < int'(OUT_W); j++) begin
      vld             = (CNT_W'(j) < count);
      q.out_valid[j]  = vld;
      q.out_bundle[j] = vld ? mem[head + PTR_W'(j)] : '0;
    end
  end

  assign q.in_ready = ready;
  assign q.count    = count;
endmodule
